// File: rtl/fetch_buf_rd.sv
// fetch_buf_rd: read-side sequencer for the 256-word fetch pixel buffer.
// Issues one read per cycle, captures the 1-cycle-latency read data into
// a 2-entry FIFO and streams it out over valid/ready. Issue is credit-gated
// so that back-pressure never drops a word.

`ifndef PIXEL_WIDTH
// Fallback when enc_defines.v is not part of the compile.
`define PIXEL_WIDTH 8
`endif

module fetch_buf_rd (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic [7:0]                base_addr_i,
    input  logic [8:0]                len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      b_re_o,
    output logic [7:0]                b_addr_o,
    input  logic [`PIXEL_WIDTH*8-1:0] b_data_i,
    output logic [`PIXEL_WIDTH*8-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i
);
    localparam int DW = `PIXEL_WIDTH*8;

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t          state;
    logic [7:0]      addr_q;
    logic [8:0]      remain_q;
    logic            inflight;    // read issued last cycle; data on b_data_i now
    logic [1:0]      fifo_cnt;
    logic            wr_ptr;
    logic            rd_ptr;
    logic [DW-1:0]   fifo_mem [2];

    logic            push;
    logic            pop;
    logic [2:0]      occ;         // words that will occupy the FIFO after this cycle
    logic [1:0]      fifo_nxt;

    assign push     = inflight;
    assign pop      = valid_o & ready_i;
    assign occ      = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
    assign fifo_nxt = fifo_cnt + {1'b0, push} - {1'b0, pop};

    // A new read is only issued if its data is guaranteed a FIFO slot.
    assign b_re_o   = (state == READ) && (remain_q != 9'd0) && (occ < 3'd2);
    assign b_addr_o = addr_q;

    assign valid_o  = (fifo_cnt != 2'd0);
    assign data_o   = fifo_mem[rd_ptr];

    // Control FSM: latches the command, walks the address, signals completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= 8'd0;
            remain_q <= 9'd0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (len_i != 9'd0) begin
                            addr_q   <= base_addr_i;
                            remain_q <= len_i;
                            busy_o   <= 1'b1;
                            state    <= READ;
                        end else begin
                            done_o <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (b_re_o) begin
                        addr_q   <= addr_q + 8'd1;
                        remain_q <= remain_q - 9'd1;
                        if (remain_q == 9'd1)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Finish on the edge that empties the FIFO so done_o
                    // lands in the first cycle with nothing left to send.
                    if (!inflight && fifo_nxt == 2'd0) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-latency tracker: marks the cycle in which b_data_i is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight <= 1'b0;
        else        inflight <= b_re_o;
    end

    // Output FIFO: captures read data the cycle it appears, pops on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt    <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= b_data_i;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_buf_rd.sv
// Bench for fetch_buf_rd: a buffer model with 1-cycle read latency and
// garbage output when not read, a transfer driver that records what the
// DUT did, and scenario tasks that compare against expectations derived
// from base/len arithmetic.

`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

module tb_fetch_buf_rd;
    localparam int DW = `PIXEL_WIDTH*8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [7:0]    base_addr_i = 8'd0;
    logic [8:0]    len_i = 9'd0;
    logic          busy_o, done_o, b_re_o, valid_o;
    logic [7:0]    b_addr_o;
    logic [DW-1:0] b_data_i = '0;
    logic [DW-1:0] data_o;
    logic          ready_i = 1'b0;

    int nchk = 0;
    int nerr = 0;

    fetch_buf_rd dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
        .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .b_re_o(b_re_o),
        .b_addr_o(b_addr_o), .b_data_i(b_data_i), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i)
    );

    always #5 clk = ~clk;

    // Buffer model: registered read; output is junk whenever no read was issued.
    logic [DW-1:0] bmem [256];
    always @(posedge clk) begin
        if (b_re_o) b_data_i <= bmem[b_addr_o];
        else        b_data_i <= {$urandom, $urandom};
    end

    // Observations of the most recent transfer.
    logic [7:0]    addr_seen [$];
    logic [DW-1:0] data_seen [$];
    int first_re, last_re, first_hs, last_hs, done_cyc, done_cnt;
    int v_out, v_stab, v_done, timed_out, busy_c1, busy_done;

    function automatic logic rdy(input int mode, input int c);
        logic [3:0] pat;
        pat = 4'b1001;  // cycle%4 = 0..3 -> 1,0,0,1
        case (mode)
            0:       return 1'b1;
            1:       return (c >= 8 && c < 18) ? 1'b0 : pat[3 - (c % 4)];
            default: return ($urandom_range(2, 0) != 0);
        endcase
    endfunction

    // Drives one start at cycle 0 and records DUT activity until done_o + 3.
    task automatic run_xfer(input logic [7:0] base, input logic [8:0] len,
                            input int mode, input int extra_cyc);
        logic          pv, pr;
        logic [DW-1:0] pd;
        int issued, popped, after;
        addr_seen.delete(); data_seen.delete();
        first_re = -1; last_re = -1; first_hs = -1; last_hs = -1;
        done_cyc = -1; done_cnt = 0; v_out = 0; v_stab = 0; v_done = 0;
        timed_out = 0; busy_c1 = 0; busy_done = 1;
        issued = 0; popped = 0; after = -1;
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = base; len_i = len; ready_i = rdy(mode, 0);
        @(negedge clk);
        pv = valid_o; pr = ready_i; pd = data_o;
        for (int c = 1; c < 2000; c++) begin
            @(posedge clk); #1;
            start_i = (c == extra_cyc);
            if (c == extra_cyc) begin
                base_addr_i = ~base; len_i = 9'd3;
            end
            ready_i = rdy(mode, c);
            @(negedge clk);
            if (c == 1) busy_c1 = busy_o;
            if (b_re_o) begin
                addr_seen.push_back(b_addr_o);
                issued++;
                if (first_re < 0) first_re = c;
                last_re = c;
            end
            if (valid_o && ready_i) begin
                data_seen.push_back(data_o);
                popped++;
                if (first_hs < 0) first_hs = c;
                last_hs = c;
            end
            if (issued - popped > 2) v_out++;
            if (pv && !pr && (!valid_o || data_o !== pd)) v_stab++;
            if (done_o) begin
                done_cnt++;
                if (valid_o) v_done++;
                if (done_cyc < 0) begin
                    done_cyc = c; busy_done = busy_o; after = c;
                end
            end
            pv = valid_o; pr = ready_i; pd = data_o;
            if (after >= 0 && c >= after + 3) break;
        end
        if (after < 0) timed_out = 1;
        start_i = 1'b0; ready_i = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        nchk++; if ({busy_o, done_o, b_re_o, valid_o} !== 4'b0) begin
            nerr++; $display("FAIL reset_ctrl: got %b want 0000", {busy_o, done_o, b_re_o, valid_o}); end
        nchk++; if (b_addr_o !== 8'd0) begin
            nerr++; $display("FAIL reset_addr: got %h want 00", b_addr_o); end
        nchk++; if (data_o !== '0) begin
            nerr++; $display("FAIL reset_data: got %h want 0", data_o); end
    endtask

    task automatic test_basic;
        for (int i = 0; i < 8; i++) bmem[8'h10 + i] = DW'(8'h10 + i);
        run_xfer(8'h10, 9'd8, 0, 0);
        nchk++; if (timed_out != 0) begin nerr++; $display("FAIL basic_timeout: no done_o"); end
        nchk++; if (first_re != 1 || last_re != 8 || addr_seen.size() != 8) begin
            nerr++; $display("FAIL basic_re_cycles: got %0d..%0d n=%0d want 1..8 n=8", first_re, last_re, addr_seen.size()); end
        nchk++; if (first_hs != 3 || last_hs != 10 || data_seen.size() != 8) begin
            nerr++; $display("FAIL basic_valid_cycles: got %0d..%0d n=%0d want 3..10 n=8", first_hs, last_hs, data_seen.size()); end
        for (int i = 0; i < addr_seen.size(); i++) begin
            nchk++; if (addr_seen[i] !== 8'(8'h10 + i) || data_seen[i] !== DW'(8'h10 + i)) begin
                nerr++; $display("FAIL basic_word%0d: addr %h data %h want %h", i, addr_seen[i], data_seen[i], 8'(8'h10 + i)); break; end
        end
        nchk++; if (done_cyc != 11 || done_cnt != 1) begin
            nerr++; $display("FAIL basic_done: cycle %0d count %0d want 11/1", done_cyc, done_cnt); end
        nchk++; if (busy_c1 != 1 || busy_done != 0) begin
            nerr++; $display("FAIL basic_busy: c1=%0d at_done=%0d want 1/0", busy_c1, busy_done); end
    endtask

    task automatic test_wrap;
        run_xfer(8'hFE, 9'd4, 0, 0);
        nchk++; if (addr_seen.size() != 4 || data_seen.size() != 4) begin
            nerr++; $display("FAIL wrap_count: addr %0d data %0d want 4", addr_seen.size(), data_seen.size()); end
        for (int i = 0; i < 4 && i < data_seen.size() && i < addr_seen.size(); i++) begin
            nchk++; if (addr_seen[i] !== 8'(8'hFE + i) || data_seen[i] !== bmem[8'(8'hFE + i)]) begin
                nerr++; $display("FAIL wrap_word%0d: addr %h data %h want %h/%h", i, addr_seen[i], data_seen[i], 8'(8'hFE + i), bmem[8'(8'hFE + i)]); break; end
        end
    endtask

    task automatic test_back_pressure;
        run_xfer(8'h33, 9'd6, 1, 0);
        nchk++; if (v_out != 0) begin nerr++; $display("FAIL bp_outstanding: %0d cycles over 2, want 0", v_out); end
        nchk++; if (v_stab != 0) begin nerr++; $display("FAIL bp_stable: %0d unstable stalls, want 0", v_stab); end
        nchk++; if (data_seen.size() != 6 || done_cnt != 1 || v_done != 0) begin
            nerr++; $display("FAIL bp_count: words %0d done %0d overlap %0d want 6/1/0", data_seen.size(), done_cnt, v_done); end
        for (int i = 0; i < data_seen.size(); i++) begin
            nchk++; if (data_seen[i] !== bmem[8'(8'h33 + i)]) begin
                nerr++; $display("FAIL bp_word%0d: got %h want %h", i, data_seen[i], bmem[8'(8'h33 + i)]); break; end
        end
    endtask

    task automatic test_random;
        logic [7:0] b;
        logic [8:0] l;
        for (int t = 0; t < 6; t++) begin
            b = 8'($urandom);
            l = 9'($urandom_range(40, 1));
            run_xfer(b, l, 2, 0);
            nchk++; if (data_seen.size() != int'(l) || v_out != 0 || v_stab != 0 || v_done != 0 || done_cnt != 1) begin
                nerr++; $display("FAIL rand%0d_proto: words %0d/%0d out %0d stab %0d ovl %0d done %0d",
                                 t, data_seen.size(), l, v_out, v_stab, v_done, done_cnt); end
            for (int i = 0; i < data_seen.size(); i++) begin
                nchk++; if (data_seen[i] !== bmem[8'(b + i)]) begin
                    nerr++; $display("FAIL rand%0d_word%0d: got %h want %h", t, i, data_seen[i], bmem[8'(b + i)]); break; end
            end
        end
    endtask

    task automatic test_zero_len;
        run_xfer(8'h55, 9'd0, 0, 0);
        nchk++; if (done_cyc != 1 || done_cnt != 1) begin
            nerr++; $display("FAIL zero_done: cycle %0d count %0d want 1/1", done_cyc, done_cnt); end
        nchk++; if (addr_seen.size() != 0 || data_seen.size() != 0 || busy_c1 != 0) begin
            nerr++; $display("FAIL zero_activity: re %0d valid %0d busy %0d want 0/0/0", addr_seen.size(), data_seen.size(), busy_c1); end
    endtask

    task automatic test_full_len;
        run_xfer(8'h80, 9'd256, 0, 0);
        nchk++; if (addr_seen.size() != 256 || data_seen.size() != 256 || done_cnt != 1 || done_cyc != 259) begin
            nerr++; $display("FAIL full_count: re %0d words %0d done %0d@%0d want 256/256/1@259",
                             addr_seen.size(), data_seen.size(), done_cnt, done_cyc); end
        nchk++; if (addr_seen.size() == 256 && (addr_seen[127] !== 8'hFF || addr_seen[128] !== 8'h00)) begin
            nerr++; $display("FAIL full_wrap: got %h,%h want ff,00", addr_seen[127], addr_seen[128]); end
        for (int i = 0; i < data_seen.size(); i++) begin
            nchk++; if (data_seen[i] !== bmem[8'(8'h80 + i)]) begin
                nerr++; $display("FAIL full_word%0d: got %h want %h", i, data_seen[i], bmem[8'(8'h80 + i)]); break; end
        end
    endtask

    task automatic test_restart;
        int dseen;
        // A start pulsed while busy must not disturb the running transfer.
        run_xfer(8'h40, 9'd6, 0, 3);
        nchk++; if (addr_seen.size() != 6 || done_cnt != 1) begin
            nerr++; $display("FAIL extra_start_count: re %0d done %0d want 6/1", addr_seen.size(), done_cnt); end
        for (int i = 0; i < addr_seen.size(); i++) begin
            nchk++; if (addr_seen[i] !== 8'(8'h40 + i)) begin
                nerr++; $display("FAIL extra_start_addr%0d: got %h want %h", i, addr_seen[i], 8'(8'h40 + i)); break; end
        end
        // Reset in the middle of a 20-word transfer.
        dseen = 0;
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = 8'h20; len_i = 9'd20; ready_i = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start_i = 1'b0;
            if (c == 5) rst_n = 1'b0;
            if (done_o) dseen++;
        end
        #1;
        nchk++; if ({busy_o, done_o, b_re_o, valid_o} !== 4'b0 || b_addr_o !== 8'd0 || data_o !== '0) begin
            nerr++; $display("FAIL midreset_outputs: ctrl %b addr %h data %h want 0", {busy_o, done_o, b_re_o, valid_o}, b_addr_o, data_o); end
        repeat (2) begin @(negedge clk); if (done_o) dseen++; end
        rst_n = 1'b1;
        nchk++; if (dseen != 0) begin nerr++; $display("FAIL midreset_done: %0d pulses want 0", dseen); end
        run_xfer(8'hF0, 9'd20, 2, 0);
        nchk++; if (data_seen.size() != 20 || done_cnt != 1) begin
            nerr++; $display("FAIL restart_count: words %0d done %0d want 20/1", data_seen.size(), done_cnt); end
        for (int i = 0; i < data_seen.size(); i++) begin
            nchk++; if (data_seen[i] !== bmem[8'(8'hF0 + i)]) begin
                nerr++; $display("FAIL restart_word%0d: got %h want %h", i, data_seen[i], bmem[8'(8'hF0 + i)]); break; end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) bmem[i] = {$urandom, $urandom};
        test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_wrap();
        test_back_pressure();
        test_zero_len();
        test_random();
        test_full_len();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
